cache_bus_master: RTL and testbench
===================================

Name: cache_bus_master

Overview:
- Initiator end of the shared cache/external-memory bus. The external responder drives the bidirectional data bus whenever bus_rw is low and releases it otherwise.
- This block accepts single read/write requests from the cache controller and sequences the bus lines: address, rw, strobe, and tristate data.
- On reads it samples the responder's data and returns it to the cache. It guarantees it never drives the data bus while the responder may be driving it.

Parameters:
- DW, 3, data bus width (matches external responder).
- AW, 8, address width.
- RD_LAT, 2, cycles bus_rw is held low before read data is sampled; legal range 1..15.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  cache request present.
- req_ready  out  1  block can accept a request.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DW  read data; valid with rsp_valid after a read.
- bus_en  out  1  transaction strobe.
- bus_addr  out  AW  bus address.
- bus_rw  out  1  1 = write/master owns bus, 0 = read/responder drives bus.
- bus_data  inout  DW  shared tristate data bus.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values: state IDLE, bus_en=0, bus_addr=0, bus_rw=1, bus_data released (all z), rsp_valid=0, rsp_rdata=0. Lat counter = 0.
- req_ready is combinational: 1 exactly when state==IDLE. Requests are ignored while rst_n=0.
- Accept: req_valid && req_ready at edge T0. At that edge, req_rw, req_addr and req_wdata are captured into internal registers.
- FSM states: IDLE, WR_SETUP, WR_DRIVE, RD_WAIT.
- IDLE:
  - bus_en=0, bus_rw=1, bus_data=z.
  - On accept, go to WR_SETUP if write, or RD_WAIT if read; load lat counter with RD_LAT-1.
- WR_SETUP (1 cycle):
  - bus_en=1, bus_rw=1, bus_addr=captured addr, bus_data still z. This is the turnaround cycle that lets the responder release the bus.
  - Next state: WR_DRIVE.
- WR_DRIVE (1 cycle):
  - bus_en=1, bus_rw=1, bus_data=captured wdata.
  - Next state: IDLE, with rsp_valid=1 in the following cycle. rsp_rdata is unchanged.
- RD_WAIT (RD_LAT cycles):
  - bus_en=1, bus_rw=0, bus_addr=captured addr, bus_data=z.
  - The counter decrements each cycle. On the edge where counter==0, bus_data is registered into rsp_rdata and the FSM returns to IDLE with rsp_valid=1.
- Latency:
  - Write: rsp_valid in cycle T0+3.
  - Read: rsp_valid in cycle T0+RD_LAT+1.
  - Back-to-back: a new request may be accepted in the same cycle rsp_valid is high (state is IDLE).
- Output registration: rsp_valid is a registered one-cycle pulse. bus_en, bus_rw and bus_addr are registered from the next state, so there are no glitches. bus_data output enable is registered and asserted only in WR_DRIVE.
- Bus ownership invariant: the output enable is never 1 in any cycle where bus_rw=0. A read followed by a write always passes through WR_SETUP, giving at least one bus_rw=1 cycle with bus_data=z.
- Data hold: rsp_rdata holds the last read value until the next read completes. Write completions do not modify it.
- req_valid while busy: no effect; the request is not captured, and the cache must hold it until req_ready.
- Reset mid-transaction: at the reset edge the FSM goes to IDLE, bus_data is released, and bus_rw=1, bus_en=0. No rsp_valid is issued for the aborted transaction.
- Undriven bus in read: whatever is sampled is passed through unchanged; the block does no X/z filtering.

Test Plan:
- Read, RD_LAT=2, addr 0x2A, responder drives 3'b110 while bus_rw=0 -> bus_rw=0 and bus_en=1 for cycles T0+1..T0+2; rsp_valid=1 at T0+3 with rsp_rdata=3'b110; req_ready=0 during T0+1..T0+2.
- Write addr 0x15 data 3'b101 -> T0+1: bus_rw=1, bus_data=zzz; T0+2: bus_data=3'b101; T0+3: rsp_valid=1, bus_data=zzz, rsp_rdata unchanged (3'b110 from the prior read).
- Read immediately followed by write (new request accepted in the rsp_valid cycle) -> monitor asserts the output enable is never high while bus_rw=0; exactly one zzz cycle appears before 3'b011 is driven.
- rst_n=0 in the second RD_WAIT cycle -> next cycle bus_en=0, bus_rw=1, bus_data=zzz, req_ready=1; no rsp_valid pulse; rsp_rdata=0.
- req_valid held high with changing req_addr during a read -> only the first address appears on bus_addr; second request accepted only in the rsp_valid cycle.
- RD_LAT=1 build, read with responder driving 3'b111 -> rsp_valid at T0+2 with rsp_rdata=3'b111.

Source files
------------

// File: rtl/cache_bus_master.sv
// cache_bus_master: initiator for the shared cache/external-memory tristate bus.
// Ports:
//   i_clk, i_rst_n                       clock, synchronous active-low reset
//   i_req_valid/o_req_ready              request handshake from the cache controller
//   i_req_rw, i_req_addr, i_req_wdata    request kind (1 = write), address, write data
//   o_rsp_valid, o_rsp_rdata             one-cycle completion pulse, last read data
//   o_bus_en, o_bus_addr, o_bus_rw       registered bus strobe, address, direction
//   io_bus_data                          shared tristate data bus
module cache_bus_master #(
  parameter int DW = 3,
  parameter int AW = 8,
  parameter int RD_LAT = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_rw,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_bus_en,
  output logic [AW-1:0] o_bus_addr,
  output logic          o_bus_rw,
  inout  wire  [DW-1:0] io_bus_data
);
  typedef enum logic [1:0] {IDLE, WR_SETUP, WR_DRIVE, RD_WAIT} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_oe, r_rsp_valid, r_bus_en, r_bus_rw;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic w_accept, w_rd_last, w_done;
  assign o_req_ready = r_state == IDLE;
  assign w_accept = i_req_valid && o_req_ready;
  assign w_rd_last = r_state == RD_WAIT && r_cnt == 4'd0;
  assign w_done = r_state == WR_DRIVE || w_rd_last;
  always_comb begin
    w_next = r_state == IDLE ? (w_accept ? (i_req_rw ? WR_SETUP : RD_WAIT) : IDLE)
           : r_state == WR_SETUP ? WR_DRIVE
           : (r_state == RD_WAIT && !w_rd_last) ? RD_WAIT
           : IDLE;
  end
  // Bus controls are registered from the next state; the data enable only
  // rises in WR_DRIVE, which is always preceded by the WR_SETUP turnaround.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_oe <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_bus_en <= 1'b0;
      r_bus_rw <= 1'b1;
      r_bus_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_bus_en <= w_next != IDLE;
      r_bus_rw <= w_next != RD_WAIT;
      r_oe <= w_next == WR_DRIVE;
      r_rsp_valid <= w_done;
      if (w_accept) begin
        r_bus_addr <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_cnt <= 4'(RD_LAT - 1);
      end else if (r_state == RD_WAIT && !w_rd_last) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_rd_last) r_rdata <= io_bus_data;
    end
  end
  assign io_bus_data = r_oe ? r_wdata : {DW{1'bz}};
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_bus_en = r_bus_en;
  assign o_bus_addr = r_bus_addr;
  assign o_bus_rw = r_bus_rw;
endmodule

// File: tb/tb_cache_bus_master.sv
// tb_cache_bus_master: vector-table and directed-sequence bench for cache_bus_master.
module tb_cache_bus_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst_n, a_v, a_rw, a_rdy, a_rsv, a_en, a_brw;
  logic [7:0] a_addr, a_badr;
  logic [2:0] a_wd, a_rd, a_rv;
  wire [2:0] a_bus;
  logic b_rst_n, b_v, b_rw, b_rdy, b_rsv, b_en, b_brw;
  logic [7:0] b_addr, b_badr;
  logic [2:0] b_wd, b_rd, b_rv;
  wire [2:0] b_bus;
  // Released bus reads back as 3'b111 through the pull-ups.
  for (genvar g = 0; g < 3; g++) begin : pu
    pullup (a_bus[g]);
    pullup (b_bus[g]);
  end
  // Responder drives whenever bus_rw is low.
  assign a_bus = a_brw ? 3'bzzz : a_rv;
  assign b_bus = b_brw ? 3'bzzz : b_rv;
  cache_bus_master #(.DW(3), .AW(8), .RD_LAT(2)) dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_req_valid(a_v), .o_req_ready(a_rdy),
    .i_req_rw(a_rw), .i_req_addr(a_addr), .i_req_wdata(a_wd),
    .o_rsp_valid(a_rsv), .o_rsp_rdata(a_rd), .o_bus_en(a_en),
    .o_bus_addr(a_badr), .o_bus_rw(a_brw), .io_bus_data(a_bus));
  cache_bus_master #(.DW(3), .AW(8), .RD_LAT(1)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_req_valid(b_v), .o_req_ready(b_rdy),
    .i_req_rw(b_rw), .i_req_addr(b_addr), .i_req_wdata(b_wd),
    .o_rsp_valid(b_rsv), .o_rsp_rdata(b_rd), .o_bus_en(b_en),
    .o_bus_addr(b_badr), .o_bus_rw(b_brw), .io_bus_data(b_bus));
  typedef struct packed {
    logic rst_n, v, rw;
    logic [7:0] addr;
    logic [2:0] wd, rv;
    logic [17:0] exp;
  } vec_t;
  vec_t vt[18];
  int n_cmp = 0, n_bad = 0;
  function automatic logic [17:0] pk(logic rdy, logic rsv, logic [2:0] rd, logic en,
                                     logic brw, logic [7:0] badr, logic [2:0] bd);
    return {rdy, rsv, rd, en, brw, badr, bd};
  endfunction
  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy/rsv/rd/en/rw/addr/data=%0b/%0b/%h/%0b/%0b/%h/%h want %0b/%0b/%h/%0b/%0b/%h/%h",
               name, act[17], act[16], act[15:13], act[12], act[11], act[10:3], act[2:0],
               exp[17], exp[16], exp[15:13], exp[12], exp[11], exp[10:3], exp[2:0]);
    end
  endtask
  initial begin
    //           rst  v    rw   addr   wd    rv      rdy  rsv  rd    en   rw   addr   data
    vt[0]  = '{1'b0, 1'b1, 1'b0, 8'h2A, 3'd0, 3'd6, pk(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd7)};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd6, pk(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd7)};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 8'h2A, 3'd0, 3'd6, pk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h2A, 3'd6)};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd6, pk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h2A, 3'd6)};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd6, pk(1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 8'h2A, 3'd7)};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 8'h15, 3'd5, 3'd0, pk(1'b0, 1'b0, 3'd6, 1'b1, 1'b1, 8'h15, 3'd7)};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, pk(1'b0, 1'b0, 3'd6, 1'b1, 1'b1, 8'h15, 3'd5)};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, pk(1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 8'h15, 3'd7)};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, pk(1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 8'h15, 3'd7)};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 8'h40, 3'd0, 3'd3, pk(1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 8'h40, 3'd3)};
    vt[10] = '{1'b1, 1'b1, 1'b0, 8'h41, 3'd0, 3'd3, pk(1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 8'h40, 3'd3)};
    vt[11] = '{1'b1, 1'b1, 1'b0, 8'h42, 3'd0, 3'd3, pk(1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 8'h40, 3'd7)};
    vt[12] = '{1'b1, 1'b1, 1'b1, 8'h43, 3'd3, 3'd3, pk(1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 8'h43, 3'd7)};
    vt[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd3, pk(1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 8'h43, 3'd3)};
    vt[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd3, pk(1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 8'h43, 3'd7)};
    vt[15] = '{1'b1, 1'b1, 1'b0, 8'h2A, 3'd0, 3'd5, pk(1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 8'h2A, 3'd5)};
    vt[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd5, pk(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd7)};
    vt[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd5, pk(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd7)};
    b_rst_n = 1'b0; b_v = 1'b0; b_rw = 1'b0; b_addr = '0; b_wd = '0; b_rv = '0;
    for (int i = 0; i < 18; i++) begin
      {a_rst_n, a_v, a_rw, a_addr, a_wd, a_rv} = {vt[i].rst_n, vt[i].v, vt[i].rw, vt[i].addr, vt[i].wd, vt[i].rv};
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), {a_rdy, a_rsv, a_rd, a_en, a_brw, a_badr, a_bus}, vt[i].exp);
    end
    b_rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_v = 1'b1; b_rw = 1'b0; b_addr = 8'h33; b_rv = 3'd7;
    @(posedge clk);
    @(negedge clk);
    b_v = 1'b0;
    check("lat1_wait", {b_rdy, b_rsv, b_rd, b_en, b_brw, b_badr, b_bus}, pk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h33, 3'd7));
    @(posedge clk);
    @(negedge clk);
    check("lat1_rsp", {b_rdy, b_rsv, b_rd, b_en, b_brw, b_badr, b_bus}, pk(1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 8'h33, 3'd7));
    @(posedge clk);
    @(negedge clk);
    check("lat1_idle", {b_rdy, b_rsv, b_rd, b_en, b_brw, b_badr, b_bus}, pk(1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 8'h33, 3'd7));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
